// File: rtl/poly_challenge_stream.sv
// ---------------------------------------------------------------------------
// poly_challenge_stream
//
// Purpose:
//   SampleInBall for ML-DSA-44/65/87. Builds the challenge polynomial c
//   (exactly tau coefficients equal to +/-1, all others 0) from a SHAKE256
//   byte stream pulled over a ready/valid link from a shared squeezer. The
//   finished polynomial is streamed out one coefficient per handshake.
//
// Parameters:
//   N        number of coefficients (power of 2, 2..256)
//   TAU_MAX  largest tau accepted (<= 64, sign word is 64 bits)
//   COEFF_W  output coefficient width, two's complement
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   start      in   one-cycle request, sampled only in IDLE
//   tau        in   nonzero count, latched when start is accepted
//   in_byte    in   XOF byte
//   in_valid   in   in_byte is valid
//   in_ready   out  block accepts in_byte this cycle (SIGNS / SAMPLE)
//   out_coeff  out  c[out_idx], sign-extended to COEFF_W
//   out_idx    out  coefficient index
//   out_valid  out  out_coeff / out_idx are valid (OUT)
//   out_ready  in   downstream accepts this cycle
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last coefficient is accepted
//   err        out  one-cycle pulse when start carried an illegal tau
//   dbg_state  out  current FSM state (debug observation only)
//
// Handshake semantics (both links): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds its data stable
// while valid is high and ready is low; ready never depends on valid.
// ---------------------------------------------------------------------------
module poly_challenge_stream #(
    parameter int N       = 256,
    parameter int TAU_MAX = 60,
    parameter int COEFF_W = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [6:0]           tau,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [COEFF_W-1:0]   out_coeff,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    // AW indexes the store; IW lets i reach N; CW is wide enough to hold
    // both a zero-extended byte and i for the rejection compare.
    localparam int AW = $clog2(N);
    localparam int IW = AW + 1;
    localparam int CW = (IW > 8) ? IW : 8;

    localparam logic [IW-1:0] N_I      = IW'(N);
    localparam logic [IW-1:0] N_LAST_I = IW'(N - 1);
    localparam logic [AW-1:0] N_LAST_A = AW'(N - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SIGNS  = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_OUT    = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    // 2-bit coefficient codes: the code is the coefficient itself in
    // two's complement, so decoding is a plain sign extension.
    localparam logic [1:0] C_ZERO = 2'b00;
    localparam logic [1:0] C_POS  = 2'b01;
    localparam logic [1:0] C_NEG  = 2'b11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]    state_q,    state_d;
    logic [63:0]   signs_q,    signs_d;
    logic [IW-1:0] i_q,        i_d;
    logic [AW-1:0] pos_q,      pos_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic          err_q,      err_d;
    logic [1:0]    store_q [N];

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic          tau_legal;
    logic [31:0]   tau_ext;
    logic          in_fire;
    logic          out_fire;
    logic [CW-1:0] b_ext;
    logic [CW-1:0] i_ext;
    logic          b_accept;
    logic [AW-1:0] b_idx;
    logic [AW-1:0] i_idx;
    logic [1:0]    sign_code;
    logic          store_clr;
    logic          smp_we;
    logic [1:0]    out_code;

    assign tau_ext   = {25'd0, tau};
    assign tau_legal = (tau_ext != 32'd0) &&
                       (tau_ext <= 32'(TAU_MAX)) &&
                       (tau_ext <= 32'(N));

    assign in_ready  = (state_q == ST_SIGNS) || (state_q == ST_SAMPLE);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign dbg_state = state_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Rejection sampling: byte b is usable only if b <= i. Both sides are
    // zero-extended to a common width so bytes above N never alias.
    assign b_ext    = CW'(in_byte);
    assign i_ext    = CW'(i_q);
    assign b_accept = (b_ext <= i_ext);

    // Only meaningful when b_accept holds, in which case b < N fits AW bits.
    assign b_idx     = in_byte[AW-1:0];
    assign i_idx     = i_q[AW-1:0];
    assign sign_code = signs_q[0] ? C_NEG : C_POS;

    assign out_code  = store_q[pos_q];
    assign out_coeff = {{(COEFF_W-2){out_code[1]}}, out_code};
    assign out_idx   = pos_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        signs_d    = signs_q;
        i_d        = i_q;
        pos_d      = pos_q;
        byte_cnt_d = byte_cnt_q;
        err_d      = 1'b0;
        store_clr  = 1'b0;
        smp_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (tau_legal) begin
                        // tau <= N < 2^IW, so the cast keeps every bit.
                        i_d        = N_I - IW'(tau);
                        pos_d      = '0;
                        byte_cnt_d = 3'd0;
                        signs_d    = 64'd0;
                        store_clr  = 1'b1;
                        state_d    = ST_SIGNS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_SIGNS: begin
                if (in_fire) begin
                    // Little endian: byte k lands in signs[8k+7:8k].
                    signs_d[{byte_cnt_q, 3'b000} +: 8] = in_byte;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                if (in_fire && b_accept) begin
                    smp_we  = 1'b1;
                    signs_d = signs_q >> 1;
                    i_d     = i_q + IW'(1);
                    if (i_q == N_LAST_I) begin
                        state_d = ST_OUT;
                    end
                end
            end

            ST_OUT: begin
                if (out_fire) begin
                    pos_d = pos_q + AW'(1);
                    if (pos_q == N_LAST_A) begin
                        state_d = ST_FIN;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            signs_q    <= 64'd0;
            i_q        <= '0;
            pos_q      <= '0;
            byte_cnt_q <= 3'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            signs_q    <= signs_d;
            i_q        <= i_d;
            pos_q      <= pos_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient store
    // The swap reads the old store[b] into store[i], then writes the sign
    // into store[b]. The sign write is issued last so that when b == i it
    // takes precedence and c[i] ends up +/-1 rather than the stale value.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n || store_clr) begin
            for (int j = 0; j < N; j++) begin
                store_q[j] <= C_ZERO;
            end
        end else if (smp_we) begin
            store_q[i_idx] <= store_q[b_idx];
            store_q[b_idx] <= sign_code;
        end
    end

endmodule

// File: tb/tb_poly_challenge_stream.sv
// ---------------------------------------------------------------------------
// tb_poly_challenge_stream
//
// Self-checking bench for poly_challenge_stream (N=256, TAU_MAX=60).
// Expected polynomials come from a direct SampleInBall reference written
// over a plain integer array and the byte stream queue.
// ---------------------------------------------------------------------------
module tb_poly_challenge_stream;

    localparam int N       = 256;
    localparam int TAU_MAX = 60;
    localparam int COEFF_W = 32;
    localparam int AW      = $clog2(N);

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic               clock = 1'b0;
    logic               reset_n;
    logic               start;
    logic [6:0]         tau;
    logic [7:0]         in_byte;
    logic               in_valid;
    logic               in_ready;
    logic [COEFF_W-1:0] out_coeff;
    logic [AW-1:0]      out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic               err;
    logic [2:0]         dbg_state;

    always #5 clock = ~clock;

    poly_challenge_stream #(
        .N       (N),
        .TAU_MAX (TAU_MAX),
        .COEFF_W (COEFF_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .tau       (tau),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_coeff (out_coeff),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] stream[$];
    int         exp_c[N];
    int         got_c[N];
    int         ref_c[N];
    int         exp_consumed;

    // ------------------------------------------------------------------
    // Reference model: textbook SampleInBall over the stream queue.
    // ------------------------------------------------------------------
    task automatic model(input int t);
        logic [63:0] s;
        int          p;
        int          b;
        for (int j = 0; j < N; j++) exp_c[j] = 0;
        s = 64'd0;
        for (int k = 0; k < 8; k++) s[8*k +: 8] = stream[k];
        p = 8;
        for (int i = N - t; i < N; i++) begin
            do begin
                b = int'(stream[p]);
                p++;
            end while (b > i);
            exp_c[i] = exp_c[b];
            exp_c[b] = s[0] ? -1 : 1;
            s = s >> 1;
        end
        exp_consumed = p;
    endtask

    task automatic make_random_stream(input int len);
        stream.delete();
        for (int k = 0; k < len; k++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    // ------------------------------------------------------------------
    // Driver: one full operation, result collected into got_c.
    // Protocol properties of the run are checked inline.
    // ------------------------------------------------------------------
    task automatic run_op(input int t, input bit gaps, input bit stalls, input string name);
        int         idx;
        int         cyc;
        int         n_out;
        int         exp_idx;
        int         order_bad;
        int         hold_bad;
        bit         fire;
        bit         stalled_prev;
        logic [COEFF_W-1:0] held_coeff;
        logic [AW-1:0]      held_idx;

        for (int j = 0; j < N; j++) got_c[j] = 99;
        @(negedge clock);
        start = 1'b1;
        tau   = 7'(t);
        @(negedge clock);
        start = 1'b0;

        idx = 0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 4000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_byte  = (idx < stream.size()) ? stream[idx] : 8'h00;
            #1;
            fire = in_valid && (in_ready === 1'b1);
            @(negedge clock);
            if (fire) idx++;
            cyc++;
        end
        in_valid = 1'b0;

        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s in_phase_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, cyc);
            return;
        end
        checks++;
        if (idx != exp_consumed) begin
            errors++;
            $display("FAIL %s bytes_consumed: got %0d, required %0d", name, idx, exp_consumed);
        end
        if (!gaps) begin
            checks++;
            if (cyc != exp_consumed) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, exp_consumed);
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_in_out: got %b, required 0", name, in_ready);
        end

        n_out        = 0;
        exp_idx      = 0;
        order_bad    = 0;
        hold_bad     = 0;
        stalled_prev = 1'b0;
        cyc          = 0;
        while (n_out < N && cyc < 8000) begin
            out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (out_valid !== 1'b1) break;
            if (stalled_prev && (out_idx !== held_idx || out_coeff !== held_coeff)) hold_bad++;
            if (out_idx !== AW'(exp_idx)) order_bad++;
            if (out_ready) begin
                got_c[out_idx] = int'($signed(out_coeff));
                n_out++;
                exp_idx++;
                stalled_prev = 1'b0;
            end else begin
                stalled_prev = 1'b1;
                held_idx     = out_idx;
                held_coeff   = out_coeff;
            end
            @(negedge clock);
            cyc++;
        end
        out_ready = 1'b0;

        checks++;
        if (n_out != N) begin
            errors++;
            $display("FAIL %s out_count: got %0d coefficients, required %0d", name, n_out, N);
        end
        checks++;
        if (order_bad != 0) begin
            errors++;
            $display("FAIL %s out_idx_order: %0d out-of-order indices, required 0", name, order_bad);
        end
        if (stalls) begin
            checks++;
            if (hold_bad != 0) begin
                errors++;
                $display("FAIL %s out_hold: %0d changes while stalled, required 0", name, hold_bad);
            end
        end
        #1;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b out_valid=%b busy=%b, required 1 0 1", name, done, out_valid, busy);
        end
        @(negedge clock);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b done=%b err=%b, required all 0",
                     in_ready, out_valid, busy, done, err);
        end
        checks++;
        if (out_coeff !== '0 || out_idx !== '0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: out_coeff=%0h out_idx=%0d state=%0d, required 0 0 0", out_coeff, out_idx, dbg_state);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_tau1();
        int bad;
        int nz;
        stream.delete();
        for (int k = 0; k < 8; k++) stream.push_back(8'h00);
        stream.push_back(8'd255);
        for (int k = 0; k < 4; k++) stream.push_back(8'hAA);
        model(1);
        run_op(1, 1'b0, 1'b0, "tau1");
        bad = 0;
        nz  = 0;
        for (int j = 0; j < N; j++) begin
            if (got_c[j] != exp_c[j]) bad++;
            if (got_c[j] != 0) nz++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tau1 coeffs: %0d wrong coefficients, required 0", bad);
        end
        checks++;
        if (got_c[255] != 1 || nz != 1) begin
            errors++;
            $display("FAIL tau1 c255: c[255]=%0d nonzero=%0d, required 1 1", got_c[255], nz);
        end
    endtask

    task automatic test_tau2_beq();
        int bad;
        int nz;
        stream.delete();
        stream.push_back(8'h01);
        for (int k = 0; k < 7; k++) stream.push_back(8'h00);
        stream.push_back(8'd255);
        stream.push_back(8'd254);
        stream.push_back(8'd3);
        for (int k = 0; k < 4; k++) stream.push_back(8'h00);
        model(2);
        run_op(2, 1'b0, 1'b0, "tau2");
        bad = 0;
        nz  = 0;
        for (int j = 0; j < N; j++) begin
            if (got_c[j] != exp_c[j]) bad++;
            if (got_c[j] != 0) nz++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tau2 coeffs: %0d wrong coefficients, required 0", bad);
        end
        checks++;
        if (got_c[254] != -1 || got_c[3] != 1 || nz != 2) begin
            errors++;
            $display("FAIL tau2 b_eq_i: c[254]=%0d c[3]=%0d nonzero=%0d, required -1 1 2", got_c[254], got_c[3], nz);
        end
    endtask

    task automatic test_illegal_tau();
        int bad_taus[3];
        bad_taus = '{0, 61, 127};
        foreach (bad_taus[n]) begin
            @(negedge clock);
            start    = 1'b1;
            tau      = 7'(bad_taus[n]);
            in_valid = 1'b1;
            in_byte  = 8'h00;
            @(negedge clock);
            start = 1'b0;
            #1;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL illegal_tau%0d pulse: err=%b busy=%b in_ready=%b, required 1 0 0",
                         bad_taus[n], err, busy, in_ready);
            end
            @(negedge clock);
            #1;
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL illegal_tau%0d after: err=%b busy=%b in_ready=%b, required 0 0 0",
                         bad_taus[n], err, busy, in_ready);
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic test_random_tau49();
        int bad;
        int nz;
        for (int seed = 0; seed < 20; seed++) begin
            make_random_stream(8 + 600);
            model(49);
            run_op(49, 1'b0, 1'b0, "tau49");
            bad = 0;
            nz  = 0;
            for (int j = 0; j < N; j++) begin
                if (got_c[j] != exp_c[j]) bad++;
                if (got_c[j] != 0) nz++;
            end
            checks++;
            if (bad != 0 || nz != 49) begin
                errors++;
                $display("FAIL tau49 run%0d: %0d wrong coefficients, %0d nonzero, required 0 and 49", seed, bad, nz);
            end
        end
    endtask

    task automatic test_stall_tau39();
        int bad_ref;
        int bad_model;
        make_random_stream(8 + 600);
        model(39);
        run_op(39, 1'b0, 1'b0, "tau39_clean");
        for (int j = 0; j < N; j++) ref_c[j] = got_c[j];
        run_op(39, 1'b1, 1'b1, "tau39_stall");
        bad_ref   = 0;
        bad_model = 0;
        for (int j = 0; j < N; j++) begin
            if (got_c[j] != ref_c[j]) bad_ref++;
            if (got_c[j] != exp_c[j]) bad_model++;
        end
        checks++;
        if (bad_ref != 0) begin
            errors++;
            $display("FAIL tau39 stall_vs_clean: %0d differing coefficients, required 0", bad_ref);
        end
        checks++;
        if (bad_model != 0) begin
            errors++;
            $display("FAIL tau39 stall_vs_model: %0d wrong coefficients, required 0", bad_model);
        end
    endtask

    task automatic test_reset_mid_sample();
        int bad;
        int nz;
        make_random_stream(8 + 600);
        @(negedge clock);
        start = 1'b1;
        tau   = 7'd49;
        @(negedge clock);
        start    = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            in_byte = stream[k];
            @(negedge clock);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (dbg_state !== 3'd2) begin
            errors++;
            $display("FAIL midreset in_sample: state=%0d, required 2", dbg_state);
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset idle: busy=%b in_ready=%b out_valid=%b done=%b, required 0 0 0 0",
                     busy, in_ready, out_valid, done);
        end
        make_random_stream(8 + 600);
        model(60);
        run_op(60, 1'b1, 1'b0, "tau60_after_reset");
        bad = 0;
        nz  = 0;
        for (int j = 0; j < N; j++) begin
            if (got_c[j] != exp_c[j]) bad++;
            if (got_c[j] != 0) nz++;
        end
        checks++;
        if (bad != 0 || nz != 60) begin
            errors++;
            $display("FAIL midreset tau60: %0d wrong coefficients, %0d nonzero, required 0 and 60", bad, nz);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        tau       = 7'd0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        test_reset();
        test_tau1();
        test_tau2_beq();
        test_illegal_tau();
        test_random_tau49();
        test_stall_tau39();
        test_reset_mid_sample();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
